// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if: request/response bus between the memory-stage controller and mem_system.
interface mem_req_ctrl_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        Rd;
    logic        Wr;
    logic        Done;
    logic        Stall;
    logic        err;
    modport master (output Addr, DataIn, Rd, Wr, input DataOut, Done, Stall, err);
    modport slave  (input Addr, DataIn, Rd, Wr, output DataOut, Done, Stall, err);
endinterface

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: holds a pipeline load/store stable toward mem_system, stalls until Done,
// returns load data, counts hits/misses and latches a sticky error.
module mem_req_ctrl #(
    parameter int TIMEOUT = 63,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         i_req_addr,
    input  logic [15:0]         i_req_data,
    input  logic                i_req_rd,
    input  logic                i_req_wr,
    input  logic                i_flush,
    mem_req_ctrl_if.master      mem,
    output logic [15:0]         o_rd_data,
    output logic                o_rd_valid,
    output logic                o_pipe_stall,
    output logic                o_err_out,
    output logic [CNT_W-1:0]    o_hit_count,
    output logic [CNT_W-1:0]    o_miss_count
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t             r_state, w_next;
    logic [15:0]        r_addr, r_data, r_rd_data;
    logic               r_rd, r_wr, r_drop;
    logic [TW-1:0]      r_cnt;
    logic [CNT_W-1:0]   r_hit, r_miss;
    logic               w_valid, w_bad, w_accept, w_timeout, w_done;

    assign w_valid   = (i_req_rd | i_req_wr) & ~i_flush;
    assign w_bad     = i_req_addr[0] | (i_req_rd & i_req_wr);
    assign w_accept  = (r_state == IDLE) & w_valid & ~w_bad;
    assign w_timeout = (r_cnt == TW'(TIMEOUT - 1)) & ~mem.Done;
    // an error on the same cycle as Done wins, so the access is not counted
    assign w_done    = (r_state == BUSY) & mem.Done & ~mem.err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_valid ? (w_bad ? ERR : BUSY) : IDLE;
            BUSY:    w_next = (mem.err | w_timeout) ? ERR : (mem.Done ? IDLE : BUSY);
            default: w_next = ERR;
        endcase
    end

    assign mem.Addr     = r_addr;
    assign mem.DataIn   = r_data;
    assign mem.Rd       = (r_state == BUSY) & r_rd;
    assign mem.Wr       = (r_state == BUSY) & r_wr;
    assign o_rd_valid   = w_done & r_rd & ~r_drop & ~i_flush;
    assign o_rd_data    = o_rd_valid ? mem.DataOut : r_rd_data;
    assign o_pipe_stall = ((r_state == IDLE) & w_valid) | ((r_state == BUSY) & ~mem.Done) | (r_state == ERR);
    assign o_err_out    = r_state == ERR;
    assign o_hit_count  = r_hit;
    assign o_miss_count = r_miss;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_data    <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_drop    <= 1'b0;
            r_cnt     <= '0;
            r_rd_data <= '0;
            r_hit     <= '0;
            r_miss    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= i_req_addr;
                r_data <= i_req_wr ? i_req_data : 16'h0;
                r_rd   <= i_req_rd;
                r_wr   <= i_req_wr;
                r_cnt  <= '0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + TW'(1);
            end
            r_drop <= ((r_state == BUSY) & (w_next == BUSY)) ? (r_drop | i_flush) : 1'b0;
            if (o_rd_valid)
                r_rd_data <= mem.DataOut;
            if (w_done & (r_cnt == '0))
                r_hit <= (r_hit == '1) ? r_hit : r_hit + CNT_W'(1);
            if (w_done & (r_cnt != '0))
                r_miss <= (r_miss == '1) ? r_miss : r_miss + CNT_W'(1);
        end
    end
endmodule
